// File: rtl/fp12_pkg.sv
// Shared definitions for the 12-bit float format (1 sign, 5 exponent, 6 fraction, bias 15).
// Used by the divider; the multiplier is to be migrated onto the same package.
package fp12_pkg;

   localparam int FP_W    = 12;
   localparam int EXP_W   = 5;
   localparam int FRAC_W  = 6;
   localparam int BIAS    = 15;
   localparam int EXP_SAT = 30;
   localparam int unsigned QBITS = 8;

   localparam logic [FP_W-1:0] SAT_VALUE  = 12'h7B0;
   localparam logic [FP_W-1:0] ZERO_VALUE = 12'h000;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp12_t;

   typedef enum logic [1:0] {StIdle, StDivide, StNorm, StDone} div_state_e;

   // A zero exponent field means zero; denormals are not represented.
   function automatic logic is_zero(fp12_t x);
      return x.exp == '0;
   endfunction

endpackage

// File: rtl/floating_point_divider_if.sv
// Operand/result handshake bundle for the fp12 divider.
interface floating_point_divider_if;

   logic [11:0] a;
   logic [11:0] b;
   logic        valid_in;
   logic        in_ready;
   logic [11:0] result;
   logic        valid_out;
   logic        out_ready;

   modport master (
      output a, b, valid_in, out_ready,
      input  in_ready, result, valid_out
   );

   modport slave (
      input  a, b, valid_in, out_ready,
      output in_ready, result, valid_out
   );

endinterface

// File: rtl/fp12_mant_divider.sv
// Restoring mantissa divider: one quotient bit per cycle, QBITS cycles after start_i.
module fp12_mant_divider
   import fp12_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [7:0]       dividend_i,
   input  logic [6:0]       divisor_i,
   output logic [QBITS-1:0] quot_o,
   output logic             done_o
);

   localparam int unsigned CntW = $clog2(QBITS);

   logic [7:0]       r_q, r_d;
   logic [6:0]       d_q, d_d;
   logic [QBITS-1:0] q_q, q_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             ge;
   logic [7:0]       r_sub;

   // done_o flags the cycle whose edge performs the final step.
   assign done_o = busy_q && (cnt_q == CntW'(QBITS - 1));
   assign quot_o = q_q;

   always_comb begin
      r_d    = r_q;
      d_d    = d_q;
      q_d    = q_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      ge     = r_q >= {1'b0, d_q};
      r_sub  = ge ? (r_q - {1'b0, d_q}) : r_q;
      if (start_i) begin
         r_d    = dividend_i;
         d_d    = divisor_i;
         q_d    = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         r_d   = {r_sub[6:0], 1'b0};
         q_d   = {q_q[QBITS-2:0], ge};
         cnt_d = cnt_q + 1'b1;
         if (done_o) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q    <= '0;
         d_q    <= '0;
         q_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         r_q    <= r_d;
         d_q    <= d_d;
         q_q    <= q_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/floating_point_divider.sv
// fp12 divider top: handshake FSM, special cases, exponent path and normalisation
// around the iterative mantissa core.
module floating_point_divider
   import fp12_pkg::*;
#(
   parameter int Bias   = BIAS,
   parameter int ExpSat = EXP_SAT
) (
   input  logic                      clk,
   input  logic                      rst,
   floating_point_divider_if.slave   bus_io
);

   div_state_e        state_q;
   logic              sign_q;
   logic signed [7:0] exp_q;
   logic [FP_W-1:0]   result_q;
   logic              valid_q;

   fp12_t             a_op, b_op;
   logic              accept, start;
   logic signed [7:0] exp_diff;
   logic signed [7:0] norm_exp;
   logic [5:0]        norm_frac;
   logic [FP_W-1:0]   norm_result;
   logic [QBITS-1:0]  quot;
   logic              core_done;

   assign bus_io.in_ready  = (state_q == StIdle);
   assign bus_io.result    = result_q;
   assign bus_io.valid_out = valid_q;

   always_comb begin
      a_op     = fp12_t'(bus_io.a);
      b_op     = fp12_t'(bus_io.b);
      accept   = bus_io.valid_in && (state_q == StIdle);
      start    = accept && !is_zero(a_op) && !is_zero(b_op);
      exp_diff = {3'b000, a_op.exp} - {3'b000, b_op.exp} + 8'(Bias);
   end

   // Quotient of two [1,2) mantissas lies in (0.5,2); a clear MSB needs one left shift.
   always_comb begin
      norm_exp  = quot[7] ? exp_q : exp_q - 8'sd1;
      norm_frac = quot[7] ? quot[6:1] : quot[5:0];
      if (norm_exp <= 8'sd0) begin
         norm_result = ZERO_VALUE;
      end else if (norm_exp >= $signed(8'(ExpSat))) begin
         norm_result = SAT_VALUE;
      end else begin
         norm_result = {sign_q, norm_exp[4:0], norm_frac};
      end
   end

   fp12_mant_divider u_mant (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start),
      .dividend_i ({2'b01, a_op.frac}),
      .divisor_i  ({1'b1, b_op.frac}),
      .quot_o     (quot),
      .done_o     (core_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         result_q <= ZERO_VALUE;
         valid_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  sign_q <= a_op.sign ^ b_op.sign;
                  exp_q  <= exp_diff;
                  if (is_zero(b_op)) begin
                     result_q <= SAT_VALUE;
                     valid_q  <= 1'b1;
                     state_q  <= StDone;
                  end else if (is_zero(a_op)) begin
                     result_q <= ZERO_VALUE;
                     valid_q  <= 1'b1;
                     state_q  <= StDone;
                  end else begin
                     state_q <= StDivide;
                  end
               end
            end
            StDivide: begin
               if (core_done) state_q <= StNorm;
            end
            StNorm: begin
               result_q <= norm_result;
               valid_q  <= 1'b1;
               state_q  <= StDone;
            end
            StDone: begin
               if (bus_io.out_ready) begin
                  valid_q <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_floating_point_divider.sv
// Directed self-checking bench for floating_point_divider: vector table plus
// backpressure and mid-operation reset sequences.
module tb_floating_point_divider;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   floating_point_divider_if bus ();

   floating_point_divider u_dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] a;
      logic [11:0] b;
      logic [11:0] res;
      int          lat;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [11:0] a, input logic [11:0] b, input logic [11:0] res,
                         input int lat, input int id);
      int   n;
      logic busy_ok;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.a        = a;
      bus.b        = b;
      bus.valid_in = 1'b1;
      chk($sformatf("v%0d in_ready_idle", id), 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      bus.a        = 12'hFFF;
      bus.b        = 12'h555;
      n       = 0;
      busy_ok = 1'b1;
      while (!bus.valid_out && n < 20) begin
         if (bus.in_ready) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         n++;
      end
      chk($sformatf("v%0d latency", id), 32'(n), 32'(lat));
      chk($sformatf("v%0d in_ready_busy_low", id), 32'(busy_ok), 32'd1);
      chk($sformatf("v%0d result", id), 32'(bus.result), 32'(res));
      chk($sformatf("v%0d in_ready_done", id), 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d valid_out_cleared", id), 32'(bus.valid_out), 32'd0);
      chk($sformatf("v%0d in_ready_after", id), 32'(bus.in_ready), 32'd1);
      chk($sformatf("v%0d result_kept", id), 32'(bus.result), 32'(res));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      vecs[0]  = '{a: 12'h3C0, b: 12'h400, res: 12'h380, lat: 9};  // 1.0/2.0
      vecs[1]  = '{a: 12'h3C0, b: 12'h3E0, res: 12'h395, lat: 9};  // 1.0/1.5
      vecs[2]  = '{a: 12'hBC0, b: 12'h3E0, res: 12'hB95, lat: 9};  // -1.0/1.5
      vecs[3]  = '{a: 12'h3C0, b: 12'h000, res: 12'h7B0, lat: 0};  // x/0
      vecs[4]  = '{a: 12'h000, b: 12'h3E0, res: 12'h000, lat: 0};  // 0/x
      vecs[5]  = '{a: 12'h780, b: 12'h040, res: 12'h7B0, lat: 9};  // exp 44
      vecs[6]  = '{a: 12'h040, b: 12'h780, res: 12'h000, lat: 9};  // exp -14
      vecs[7]  = '{a: 12'h420, b: 12'h3E0, res: 12'h400, lat: 9};  // 3.0/1.5
      vecs[8]  = '{a: 12'h000, b: 12'h000, res: 12'h7B0, lat: 0};  // 0/0
      vecs[9]  = '{a: 12'h3C0, b: 12'hBC0, res: 12'hBC0, lat: 9};  // 1.0/-1.0
      vecs[10] = '{a: 12'h800, b: 12'h3E0, res: 12'h000, lat: 0};  // -0/x

      rst           = 1'b1;
      bus.a         = '0;
      bus.b         = '0;
      bus.valid_in  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset result", 32'(bus.result), 32'h000);
      chk("reset valid_out", 32'(bus.valid_out), 32'd0);
      chk("reset in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, i);
      end

      // Backpressure: result held, new operands ignored while in DONE.
      begin
         int n;
         bus.out_ready = 1'b0;
         @(negedge clk);
         bus.a        = 12'h420;
         bus.b        = 12'h3E0;
         bus.valid_in = 1'b1;
         @(posedge clk);
         #1;
         bus.valid_in = 1'b0;
         n = 0;
         while (!bus.valid_out && n < 20) begin
            @(posedge clk);
            #1;
            n++;
         end
         chk("bp latency", 32'(n), 32'd9);
         for (int c = 0; c < 5; c++) begin
            bus.a        = 12'h3C0;
            bus.b        = 12'h400;
            bus.valid_in = 1'(c % 2 == 0);
            @(posedge clk);
            #1;
            chk($sformatf("bp hold%0d result", c), 32'(bus.result), 32'h400);
            chk($sformatf("bp hold%0d valid_out", c), 32'(bus.valid_out), 32'd1);
            chk($sformatf("bp hold%0d in_ready", c), 32'(bus.in_ready), 32'd0);
         end
         bus.valid_in  = 1'b0;
         bus.out_ready = 1'b1;
         @(posedge clk);
         #1;
         chk("bp release valid_out", 32'(bus.valid_out), 32'd0);
         chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
         chk("bp release result", 32'(bus.result), 32'h400);
         @(posedge clk);
         #1;
         chk("bp still idle", 32'(bus.in_ready), 32'd1);
      end

      // Reset during DIVIDE step 4 aborts immediately.
      @(negedge clk);
      bus.a        = 12'h3C0;
      bus.b        = 12'h3E0;
      bus.valid_in = 1'b1;
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre-rst in_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b1;
      #1;
      chk("rst valid_out", 32'(bus.valid_out), 32'd0);
      chk("rst result", 32'(bus.result), 32'h000);
      chk("rst in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post-rst no resume", 32'(bus.valid_out), 32'd0);
      run_op(12'h3C0, 12'h400, 12'h380, 9, 99);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
